core_run_ctrl: RTL and testbench

Execution sequencer for the SCPU core on the FPGA top level. It gates the core clock enable so the core can be halted, single-stepped, burst-stepped N instructions, or free-run at a programmable rate. Progress is tracked from the retire-valid strobe that accompanies the core's commit info. It sits between the board IO (switch/button decode) and the core clock-enable input, and adds breakpoint and watchdog stop conditions.

---
 rtl/core_run_ctrl_pkg.sv | 22 ++
 rtl/core_run_ctrl_divider.sv | 39 +++
 rtl/core_run_ctrl.sv | 157 +++++++++++++++
 tb/tb_core_run_ctrl.sv | 337 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/core_run_ctrl_pkg.sv
// Shared types and constants for the SCPU execution sequencer.
// Sits alongside the core package types (e.g. CoreInfo) used by the FPGA top level.
package core_run_ctrl_pkg;

  typedef enum logic [1:0] {
    MODE_HALT  = 2'b00,
    MODE_STEP  = 2'b01,
    MODE_BURST = 2'b10,
    MODE_RUN   = 2'b11
  } run_mode_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_STEP  = 2'b01,
    ST_RUN   = 2'b10,
    ST_FAULT = 2'b11
  } run_state_e;

  localparam int unsigned TIMEOUT_DEFAULT = 1024;
  localparam int unsigned BURST_W         = 8;

endpackage

// File: rtl/core_run_ctrl_divider.sv
// Free-run rate divider: tick once per (div+1) cycles, restartable so the
// first enable after entering STEP/RUN is issued immediately.
module core_en_divider #(
  parameter int DIV_W = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             restart_i,
  input  logic [DIV_W-1:0] div_i,
  output logic             tick_o
);

  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic [DIV_W-1:0] lim_q, lim_d;

  // The period limit is latched only on wrap/restart so a div change never
  // truncates or stretches the period in progress.
  always_comb begin
    cnt_d = cnt_q + DIV_W'(1);
    lim_d = lim_q;
    if (restart_i || (cnt_q >= lim_q)) begin
      cnt_d = '0;
      lim_d = div_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
      lim_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      lim_q <= lim_d;
    end
  end

  assign tick_o = (cnt_q == '0);

endmodule

// File: rtl/core_run_ctrl.sv
// Execution sequencer: gates the SCPU core clock enable for halt, single-step,
// burst-step and rate-divided free-run, with breakpoint and watchdog stops.
//
// state    | meaning
// ---------+------------------------------------------------------------
// ST_IDLE  | core halted, waiting for a mode/step_req start condition
// ST_STEP  | issuing until 'remaining' instructions have retired
// ST_RUN   | free-running at the divided rate while mode stays RUN
// ST_FAULT | watchdog expired; held until fault_clr
module core_run_ctrl
  import core_run_ctrl_pkg::*;
#(
  parameter int XLEN    = 64,
  parameter int CNT_W   = 32,
  parameter int TIMEOUT = TIMEOUT_DEFAULT,
  parameter int DIV_W   = 4
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic [1:0]         mode_i,
  input  logic               step_req_i,
  input  logic [BURST_W-1:0] burst_len_i,
  input  logic [DIV_W-1:0]   div_i,
  input  logic               break_en_i,
  input  logic [XLEN-1:0]    break_pc_i,
  input  logic               fault_clr_i,
  input  logic               retire_valid_i,
  input  logic [XLEN-1:0]    retire_pc_i,
  output logic               core_en_o,
  output logic               busy_o,
  output logic               brk_hit_o,
  output logic               fault_o,
  output logic [CNT_W-1:0]   retire_cnt_o
);

  localparam int WD_W = $clog2(TIMEOUT + 1);

  run_state_e         state_q;
  logic [BURST_W-1:0] remaining_q;
  logic [WD_W-1:0]    wdog_q;
  logic [CNT_W-1:0]   retire_cnt_q;
  logic               brk_hit_q;
  logic               busy_q;
  logic               fault_q;

  run_mode_e mode;
  logic      tick;
  logic      bp_hit;
  logic      last_step;
  logic      mode_exit;
  logic      stop_now;
  logic      start_step;
  logic      start_run;
  logic      wdog_trip;
  logic      core_en;

  assign mode = run_mode_e'(mode_i);

  always_comb begin
    bp_hit     = retire_valid_i && break_en_i && (retire_pc_i == break_pc_i);
    last_step  = (state_q == ST_STEP) && retire_valid_i && (remaining_q == BURST_W'(1));
    mode_exit  = (state_q == ST_RUN) && (mode != MODE_RUN);
    stop_now   = busy_q && (bp_hit || last_step || mode_exit);
    start_step = (state_q == ST_IDLE) && step_req_i &&
                 ((mode == MODE_STEP) || ((mode == MODE_BURST) && (burst_len_i != '0)));
    start_run  = (state_q == ST_IDLE) && (mode == MODE_RUN);
    // A stopping cycle must not issue: the instruction that caused the stop
    // is the last one the core executes.
    core_en    = busy_q && tick && !stop_now;
    wdog_trip  = core_en && !retire_valid_i && (wdog_q == WD_W'(TIMEOUT - 1));
  end

  core_en_divider #(
    .DIV_W (DIV_W)
  ) u_divider (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .restart_i (start_step || start_run),
    .div_i     (div_i),
    .tick_o    (tick)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= ST_IDLE;
      remaining_q  <= '0;
      wdog_q       <= '0;
      retire_cnt_q <= '0;
      brk_hit_q    <= 1'b0;
      busy_q       <= 1'b0;
      fault_q      <= 1'b0;
    end else begin
      if (retire_valid_i) begin
        retire_cnt_q <= retire_cnt_q + CNT_W'(1);
      end

      case (state_q)
        ST_IDLE: begin
          if (start_step) begin
            state_q     <= ST_STEP;
            busy_q      <= 1'b1;
            remaining_q <= (mode == MODE_STEP) ? BURST_W'(1) : burst_len_i;
            wdog_q      <= '0;
            brk_hit_q   <= 1'b0;
          end else if (start_run) begin
            state_q   <= ST_RUN;
            busy_q    <= 1'b1;
            wdog_q    <= '0;
            brk_hit_q <= 1'b0;
          end
        end

        ST_STEP, ST_RUN: begin
          if (bp_hit) begin
            state_q   <= ST_IDLE;
            busy_q    <= 1'b0;
            brk_hit_q <= 1'b1;
          end else if (last_step || mode_exit) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
          end else if (wdog_trip) begin
            state_q <= ST_FAULT;
            busy_q  <= 1'b0;
            fault_q <= 1'b1;
          end else if (retire_valid_i) begin
            wdog_q <= '0;
            if (state_q == ST_STEP) begin
              remaining_q <= remaining_q - BURST_W'(1);
            end
          end else if (core_en) begin
            wdog_q <= wdog_q + WD_W'(1);
          end
        end

        ST_FAULT: begin
          if (fault_clr_i) begin
            state_q <= ST_IDLE;
            fault_q <= 1'b0;
          end
        end

        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
          fault_q <= 1'b0;
        end
      endcase
    end
  end

  assign core_en_o    = core_en;
  assign busy_o       = busy_q;
  assign brk_hit_o    = brk_hit_q;
  assign fault_o      = fault_q;
  assign retire_cnt_o = retire_cnt_q;

endmodule

// File: tb/tb_core_run_ctrl.sv
// Directed bench for core_run_ctrl: step, burst, breakpoint, watchdog,
// precedence and mid-operation reset scenarios with hand-computed expectations.
module tb_core_run_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  mode;
  logic        step_req;
  logic [7:0]  burst_len;
  logic [3:0]  div;
  logic        break_en;
  logic [63:0] break_pc;
  logic        fault_clr;
  logic        retire_valid;
  logic [63:0] retire_pc;
  logic        core_en;
  logic        busy;
  logic        brk_hit;
  logic        fault;
  logic [31:0] retire_cnt;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  core_run_ctrl #(
    .XLEN    (64),
    .CNT_W   (32),
    .TIMEOUT (16),
    .DIV_W   (4)
  ) dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .mode_i         (mode),
    .step_req_i     (step_req),
    .burst_len_i    (burst_len),
    .div_i          (div),
    .break_en_i     (break_en),
    .break_pc_i     (break_pc),
    .fault_clr_i    (fault_clr),
    .retire_valid_i (retire_valid),
    .retire_pc_i    (retire_pc),
    .core_en_o      (core_en),
    .busy_o         (busy),
    .brk_hit_o      (brk_hit),
    .fault_o        (fault),
    .retire_cnt_o   (retire_cnt)
  );

  // Inputs change 1 time unit after the rising edge; outputs are sampled 1
  // unit later, well before the next rising edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    mode = 2'b00; step_req = 1'b0; burst_len = 8'd0; div = 4'd0;
    break_en = 1'b0; break_pc = 64'd0; fault_clr = 1'b0;
    retire_valid = 1'b0; retire_pc = 64'd0;
    rst = 1'b1;
    cyc();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    cyc();
    #1;
    n_cmp++;
    if ({core_en, busy, brk_hit, fault} !== 4'b0000) begin
      n_bad++;
      $display("FAIL reset_flags: got en/busy/brk/fault=%b expected 0000",
               {core_en, busy, brk_hit, fault});
    end
    n_cmp++;
    if (retire_cnt !== 32'd0) begin
      n_bad++;
      $display("FAIL reset_cnt: got %0d expected 0", retire_cnt);
    end
  endtask

  task automatic test_step();
    do_reset();
    mode = 2'b01; step_req = 1'b1;
    #1;
    n_cmp++;
    if (core_en !== 1'b0) begin
      n_bad++;
      $display("FAIL step_idle_en: got %b expected 0", core_en);
    end
    cyc();
    step_req = 1'b0;
    #1;
    n_cmp++;
    if ({busy, core_en} !== 2'b11) begin
      n_bad++;
      $display("FAIL step_start: got busy/en=%b expected 11", {busy, core_en});
    end
    cyc();
    retire_valid = 1'b1; retire_pc = 64'h100;
    #1;
    n_cmp++;
    if (core_en !== 1'b0) begin
      n_bad++;
      $display("FAIL step_stop_en: got %b expected 0", core_en);
    end
    cyc();
    retire_valid = 1'b0;
    #1;
    n_cmp++;
    if ({busy, core_en} !== 2'b00) begin
      n_bad++;
      $display("FAIL step_done: got busy/en=%b expected 00", {busy, core_en});
    end
    n_cmp++;
    if (retire_cnt !== 32'd1) begin
      n_bad++;
      $display("FAIL step_cnt: got %0d expected 1", retire_cnt);
    end
  endtask

  task automatic test_burst();
    int en_cnt;
    int last_en;
    logic prev_en;
    do_reset();
    mode = 2'b10; burst_len = 8'd5; div = 4'd3; step_req = 1'b1;
    cyc();
    step_req = 1'b0;
    en_cnt = 0; last_en = 0; prev_en = 1'b0;
    // Core retires one cycle after each enable; enables land on 0,4,8,12,16.
    for (int c = 0; c < 24; c++) begin
      retire_valid = prev_en;
      #1;
      if (core_en === 1'b1) begin
        n_cmp++;
        if (en_cnt == 0 ? (c != 0) : (c - last_en != 4)) begin
          n_bad++;
          $display("FAIL burst_spacing: pulse %0d at cycle %0d, previous at %0d, expected spacing 4 from cycle 0",
                   en_cnt, c, last_en);
        end
        en_cnt++;
        last_en = c;
      end
      prev_en = core_en;
      cyc();
    end
    retire_valid = 1'b0;
    #1;
    n_cmp++;
    if (en_cnt !== 5) begin
      n_bad++;
      $display("FAIL burst_pulses: got %0d expected 5", en_cnt);
    end
    n_cmp++;
    if (busy !== 1'b0 || retire_cnt !== 32'd5) begin
      n_bad++;
      $display("FAIL burst_done: got busy=%b cnt=%0d expected busy=0 cnt=5", busy, retire_cnt);
    end
    burst_len = 8'd0; step_req = 1'b1;
    cyc();
    step_req = 1'b0;
    #1;
    n_cmp++;
    if (busy !== 1'b0) begin
      n_bad++;
      $display("FAIL burst_zero: got busy=%b expected 0", busy);
    end
  endtask

  task automatic test_breakpoint();
    do_reset();
    break_en = 1'b1; break_pc = 64'h8000_0010; mode = 2'b11;
    cyc();
    #1;
    n_cmp++;
    if (busy !== 1'b1) begin
      n_bad++;
      $display("FAIL run_entry: got busy=%b expected 1", busy);
    end
    for (int k = 0; k < 5; k++) begin
      retire_valid = 1'b1;
      retire_pc = 64'h8000_0000 + 64'(4 * k);
      #1;
      n_cmp++;
      if (core_en !== (k != 4)) begin
        n_bad++;
        $display("FAIL brk_en_pc%0h: got %b expected %b", retire_pc, core_en, (k != 4));
      end
      if (k == 4) mode = 2'b00;
      cyc();
    end
    retire_valid = 1'b0;
    #1;
    n_cmp++;
    if ({busy, brk_hit} !== 2'b01 || retire_cnt !== 32'd5) begin
      n_bad++;
      $display("FAIL brk_stop: got busy/brk=%b cnt=%0d expected 01 cnt=5", {busy, brk_hit}, retire_cnt);
    end
    mode = 2'b11;
    cyc();
    #1;
    n_cmp++;
    if ({busy, brk_hit} !== 2'b10) begin
      n_bad++;
      $display("FAIL brk_clear: got busy/brk=%b expected 10", {busy, brk_hit});
    end
    mode = 2'b00;
    #1;
    n_cmp++;
    if (core_en !== 1'b0) begin
      n_bad++;
      $display("FAIL run_exit_en: got %b expected 0", core_en);
    end
    cyc();
    #1;
    n_cmp++;
    if (busy !== 1'b0) begin
      n_bad++;
      $display("FAIL run_exit: got busy=%b expected 0", busy);
    end
  endtask

  task automatic test_watchdog();
    do_reset();
    mode = 2'b01; step_req = 1'b1;
    cyc();
    step_req = 1'b0;
    for (int i = 0; i < 16; i++) begin
      step_req = (i == 5);
      #1;
      n_cmp++;
      if ({core_en, fault} !== 2'b10) begin
        n_bad++;
        $display("FAIL wdog_run%0d: got en/fault=%b expected 10", i, {core_en, fault});
      end
      cyc();
    end
    step_req = 1'b0;
    #1;
    n_cmp++;
    if ({fault, busy, core_en} !== 3'b100) begin
      n_bad++;
      $display("FAIL wdog_fault: got fault/busy/en=%b expected 100", {fault, busy, core_en});
    end
    step_req = 1'b1;
    cyc();
    step_req = 1'b0;
    #1;
    n_cmp++;
    if ({fault, busy} !== 2'b10) begin
      n_bad++;
      $display("FAIL fault_hold: got fault/busy=%b expected 10", {fault, busy});
    end
    fault_clr = 1'b1;
    cyc();
    fault_clr = 1'b0;
    #1;
    n_cmp++;
    if ({fault, busy} !== 2'b00) begin
      n_bad++;
      $display("FAIL fault_clr: got fault/busy=%b expected 00", {fault, busy});
    end
  endtask

  task automatic test_precedence();
    do_reset();
    mode = 2'b10; burst_len = 8'd5; step_req = 1'b1;
    cyc();
    step_req = 1'b0;
    for (int i = 0; i < 15; i++) cyc();
    retire_valid = 1'b1; retire_pc = 64'h200;
    #1;
    n_cmp++;
    if (core_en !== 1'b1) begin
      n_bad++;
      $display("FAIL prec_en16: got %b expected 1", core_en);
    end
    cyc();
    retire_valid = 1'b0;
    #1;
    n_cmp++;
    if ({fault, busy} !== 2'b01) begin
      n_bad++;
      $display("FAIL prec_nofault: got fault/busy=%b expected 01", {fault, busy});
    end
    retire_valid = 1'b1;
    cyc();
    retire_valid = 1'b0;
    #1;
    n_cmp++;
    if (retire_cnt !== 32'd2 || busy !== 1'b1) begin
      n_bad++;
      $display("FAIL prec_mid: got cnt=%0d busy=%b expected cnt=2 busy=1", retire_cnt, busy);
    end
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    #1;
    n_cmp++;
    if ({core_en, busy, brk_hit, fault} !== 4'b0000 || retire_cnt !== 32'd0) begin
      n_bad++;
      $display("FAIL mid_reset: got en/busy/brk/fault=%b cnt=%0d expected 0000 cnt=0",
               {core_en, busy, brk_hit, fault}, retire_cnt);
    end
    mode = 2'b11;
    cyc();
    #1;
    n_cmp++;
    if ({busy, core_en} !== 2'b11) begin
      n_bad++;
      $display("FAIL reset_then_run: got busy/en=%b expected 11", {busy, core_en});
    end
    mode = 2'b00;
    cyc();
  endtask

  initial begin
    test_reset();
    test_step();
    test_burst();
    test_breakpoint();
    test_watchdog();
    test_precedence();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation exceeded time limit, expected completion");
    $fatal(1, "time limit");
  end

endmodule
